// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/position generator with image address and optional test pattern
// Optional feature: define VGA_TESTPAT_EN to add the 12-bit colour-bar output pat_rgb.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   IMG_W_LOG2 = 8,
  parameter int   IMG_H_LOG2 = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pix_ce,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             h_disp,
  output logic                             v_disp,
  output logic                             en,
  output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr,
  output logic [9:0]                       x,
  output logic [9:0]                       y,
  output logic                             frame_start
`ifdef VGA_TESTPAT_EN
  ,
  output logic [11:0]                      pat_rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0]  H_SS_L   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  H_SE_L   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SS_L   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SE_L   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [10:0] IMG_W    = 11'(1 << IMG_W_LOG2);
  localparam logic [10:0] IMG_H    = 11'(1 << IMG_H_LOG2);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_act;
  logic       v_act;
  logic       in_img;
  logic       h_sync_on;
  logic       v_sync_on;

  // Decode the current counter position into region and sync conditions
  always_comb begin
    h_act     = (h_cnt < H_ACT_L);
    v_act     = (v_cnt < V_ACT_L);
    in_img    = ({1'b0, h_cnt} < IMG_W) && ({1'b0, v_cnt} < IMG_H);
    h_sync_on = (h_cnt >= H_SS_L) && (h_cnt < H_SE_L);
    v_sync_on = (v_cnt >= V_SS_L) && (v_cnt < V_SE_L);
  end

  // Image address leads the output stage by one tick so a registered ROM lines up with x/y
  always_comb begin
    addr = '0;
    if (in_img) begin
      addr = {v_cnt[IMG_H_LOG2-1:0], h_cnt[IMG_W_LOG2-1:0]};
    end
  end

  // Raster counters: column wraps each line, row advances on column wrap and wraps per frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST_L) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST_L) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Output stage: register the current position and its flags; frame_start is a one-clk strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      h_disp      <= 1'b0;
      v_disp      <= 1'b0;
      en          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        hsync       <= h_sync_on ? SYNC_POL : ~SYNC_POL;
        vsync       <= v_sync_on ? SYNC_POL : ~SYNC_POL;
        h_disp      <= h_act;
        v_disp      <= v_act;
        en          <= in_img && h_act && v_act;
        x           <= h_cnt;
        y           <= v_cnt;
        frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      end
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [9:0]  bar_idx;
  logic [11:0] bar_rgb;

  // Colour of the vertical bar under the current column; blanking forces black
  always_comb begin
    bar_idx = h_cnt / BAR_W;
    case (bar_idx)
      10'd0:   bar_rgb = 12'hFFF;
      10'd1:   bar_rgb = 12'hFF0;
      10'd2:   bar_rgb = 12'h0FF;
      10'd3:   bar_rgb = 12'h0F0;
      10'd4:   bar_rgb = 12'hF0F;
      10'd5:   bar_rgb = 12'hF00;
      10'd6:   bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
    if (!(h_act && v_act)) begin
      bar_rgb = 12'h000;
    end
  end

  // Pattern register shares the output-stage timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_rgb <= 12'h000;
    end else if (pix_ce) begin
      pat_rgb <= bar_rgb;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_ce = 1'b0;

  logic        hsync, vsync, h_disp, v_disp, en, frame_start;
  logic [15:0] addr;
  logic [9:0]  x, y;
  logic        s_hsync, s_vsync, s_h_disp, s_v_disp, s_en, s_frame_start;
  logic [15:0] s_addr;
  logic [9:0]  s_x, s_y;
`ifdef VGA_TESTPAT_EN
  logic [11:0] pat_rgb, s_pat_rgb;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Default 640x480 timing
  vga_timing_gen dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync), .h_disp(h_disp), .v_disp(v_disp), .en(en),
    .addr(addr), .x(x), .y(y), .frame_start(frame_start)
`ifdef VGA_TESTPAT_EN
    , .pat_rgb(pat_rgb)
`endif
  );

  // Reduced raster (400x75 total, positive sync) so whole frames fit in a short run
  vga_timing_gen #(
    .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
    .V_ACTIVE(60), .V_FP(5), .V_SYNC(2), .V_BP(8),
    .SYNC_POL(1'b1), .IMG_W_LOG2(8), .IMG_H_LOG2(8)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(s_hsync), .vsync(s_vsync), .h_disp(s_h_disp), .v_disp(s_v_disp), .en(s_en),
    .addr(s_addr), .x(s_x), .y(s_y), .frame_start(s_frame_start)
`ifdef VGA_TESTPAT_EN
    , .pat_rgb(s_pat_rgb)
`endif
  );

  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pix_ce = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if ({x, y} !== 20'd0) begin fails++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y); end
    checks++; if ({h_disp, v_disp, en, frame_start} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {h_disp, v_disp, en, frame_start}); end
    checks++; if ({hsync, vsync} !== 2'b11) begin fails++; $display("FAIL reset_sync: got %b expected 11", {hsync, vsync}); end
    checks++; if ({s_hsync, s_vsync} !== 2'b00) begin fails++; $display("FAIL reset_sync_pos: got %b expected 00", {s_hsync, s_vsync}); end
    checks++; if (addr !== 16'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_hsync();
    int lo_cnt = 0, minx = 1023, maxx = 0, fall1 = 0, fall2 = 0;
    logic prev;
    prev = hsync;
    for (int n = 1; n <= 1700; n++) begin
      tick(1'b1);
      if (n == 1) begin
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL hs_frame_start: got %b expected 1", frame_start); end
      end
      if (n == 2) begin
        checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL hs_frame_start_drop: got %b expected 0", frame_start); end
      end
`ifdef VGA_TESTPAT_EN
      if (n == 1) begin checks++; if (pat_rgb !== 12'hFFF) begin fails++; $display("FAIL pat_x0: got %h expected fff", pat_rgb); end end
      if (n == 81) begin checks++; if (pat_rgb !== 12'hFF0) begin fails++; $display("FAIL pat_x80: got %h expected ff0", pat_rgb); end end
      if (n == 601) begin checks++; if (pat_rgb !== 12'h000) begin fails++; $display("FAIL pat_x600: got %h expected 000", pat_rgb); end end
      if (n == 701) begin checks++; if (pat_rgb !== 12'h000) begin fails++; $display("FAIL pat_x700: got %h expected 000", pat_rgb); end end
`endif
      if (hsync === 1'b0) begin
        lo_cnt++;
        if (int'(x) < minx) minx = int'(x);
        if (int'(x) > maxx) maxx = int'(x);
        if (prev === 1'b1) begin
          if (fall1 == 0) fall1 = n; else if (fall2 == 0) fall2 = n;
        end
      end
      prev = hsync;
    end
    checks++; if (lo_cnt != 192) begin fails++; $display("FAIL hs_width: got %0d low ticks expected 192", lo_cnt); end
    checks++; if (minx != 656 || maxx != 751) begin fails++; $display("FAIL hs_x_range: got %0d..%0d expected 656..751", minx, maxx); end
    checks++; if (fall1 != 657) begin fails++; $display("FAIL hs_first_fall: got %0d expected 657", fall1); end
    checks++; if (fall2 - fall1 != 800) begin fails++; $display("FAIL hs_period: got %0d expected 800", fall2 - fall1); end
  endtask

  task automatic test_addr();
    do_reset();
    repeat (2405) tick(1'b1);
    checks++; if (addr !== 16'd773) begin fails++; $display("FAIL addr_5_3: got %0d expected 773", addr); end
    checks++; if (s_addr !== 16'd1541) begin fails++; $display("FAIL addr_small_5_6: got %0d expected 1541", s_addr); end
    tick(1'b1);
    checks++; if (x !== 10'd5 || y !== 10'd3) begin fails++; $display("FAIL pos_5_3: got %0d,%0d expected 5,3", x, y); end
    checks++; if ({en, h_disp, v_disp} !== 3'b111) begin fails++; $display("FAIL flags_5_3: got %b expected 111", {en, h_disp, v_disp}); end
    repeat (8256 - 2406) tick(1'b1);
    checks++; if (addr !== 16'd0) begin fails++; $display("FAIL addr_256_10: got %0d expected 0", addr); end
    tick(1'b1);
    checks++; if ({en, h_disp, v_disp} !== 3'b011) begin fails++; $display("FAIL flags_256_10: got %b expected 011", {en, h_disp, v_disp}); end
    checks++; if (x !== 10'd256 || y !== 10'd10) begin fails++; $display("FAIL pos_256_10: got %0d,%0d expected 256,10", x, y); end
  endtask

  task automatic test_reset_mid();
    #2 reset = 1'b1;
    #1;
    checks++; if ({x, y} !== 20'd0) begin fails++; $display("FAIL mid_reset_xy: got %0d,%0d expected 0,0", x, y); end
    checks++; if ({h_disp, v_disp, en, frame_start, hsync, vsync} !== 6'b000011) begin fails++; $display("FAIL mid_reset_flags: got %b expected 000011", {h_disp, v_disp, en, frame_start, hsync, vsync}); end
    checks++; if (addr !== 16'd0) begin fails++; $display("FAIL mid_reset_addr: got %0d expected 0", addr); end
    tick(1'b1);
    tick(1'b1);
    checks++; if ({x, y, frame_start} !== 21'd0) begin fails++; $display("FAIL held_reset: got x=%0d y=%0d fs=%b expected 0 0 0", x, y, frame_start); end
    reset = 1'b0;
    tick(1'b1);
    checks++; if ({x, y} !== 20'd0 || frame_start !== 1'b1) begin fails++; $display("FAIL post_reset_first: got x=%0d y=%0d fs=%b expected 0 0 1", x, y, frame_start); end
    checks++; if ({en, h_disp, v_disp} !== 3'b111) begin fails++; $display("FAIL post_reset_flags: got %b expected 111", {en, h_disp, v_disp}); end
    tick(1'b0);
    checks++; if (frame_start !== 1'b0 || x !== 10'd0) begin fails++; $display("FAIL post_reset_hold: got fs=%b x=%0d expected 0 0", frame_start, x); end
  endtask

  task automatic test_hdisp_edge();
    do_reset();
    repeat (640) tick(1'b1);
    checks++; if (addr !== 16'd0) begin fails++; $display("FAIL addr_640_0: got %0d expected 0", addr); end
    tick(1'b1);
    checks++; if ({h_disp, v_disp, en} !== 3'b010 || x !== 10'd640) begin fails++; $display("FAIL flags_640_0: got %b x=%0d expected 010 x=640", {h_disp, v_disp, en}, x); end
  endtask

  task automatic test_frame();
    int fs1 = 0, fs2 = 0, fs_cnt = 0, vs_cnt = 0, miny = 1023, maxy = 0;
    do_reset();
    for (int n = 1; n <= 30010; n++) begin
      tick(1'b1);
      if (s_frame_start === 1'b1) begin
        fs_cnt++;
        if (fs1 == 0) fs1 = n; else if (fs2 == 0) fs2 = n;
      end
      if (s_vsync === 1'b1) begin
        vs_cnt++;
        if (int'(s_y) < miny) miny = int'(s_y);
        if (int'(s_y) > maxy) maxy = int'(s_y);
      end
      if (n == 23920) begin
        checks++; if (s_x !== 10'd319 || s_y !== 10'd59) begin fails++; $display("FAIL small_last_pos: got %0d,%0d expected 319,59", s_x, s_y); end
        checks++; if ({s_en, s_h_disp, s_v_disp} !== 3'b011) begin fails++; $display("FAIL small_last_flags: got %b expected 011", {s_en, s_h_disp, s_v_disp}); end
      end
      if (n == 30001) begin
        checks++; if (s_x !== 10'd0 || s_y !== 10'd0) begin fails++; $display("FAIL small_wrap_pos: got %0d,%0d expected 0,0", s_x, s_y); end
      end
    end
    checks++; if (fs1 != 1 || fs2 - fs1 != 30000 || fs_cnt != 2) begin fails++; $display("FAIL frame_period: got first=%0d period=%0d pulses=%0d expected 1 30000 2", fs1, fs2 - fs1, fs_cnt); end
    checks++; if (vs_cnt != 800 || miny != 65 || maxy != 66) begin fails++; $display("FAIL vsync_window: got %0d ticks y=%0d..%0d expected 800 y=65..66", vs_cnt, miny, maxy); end
  endtask

  task automatic test_quarter_rate();
    int t = 0, bad = 0, fs_cnt = 0, fall1 = -1, fall2 = -1, rise1 = -1;
    logic ce;
    logic prev;
    do_reset();
    prev = hsync;
    for (int c = 0; c < 7000; c++) begin
      ce = ((c % 4) == 0);
      tick(ce);
      if (ce) t++;
      if (int'(x) != (t - 1) % 800) bad++;
      if (frame_start === 1'b1) fs_cnt++;
      if (c == 0) begin
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL q_frame_start: got %b expected 1", frame_start); end
      end
      if (prev === 1'b1 && hsync === 1'b0) begin
        if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
      end
      if (prev === 1'b0 && hsync === 1'b1 && rise1 < 0) rise1 = c;
      prev = hsync;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL q_x_stable: got %0d bad samples expected 0", bad); end
    checks++; if (fs_cnt != 1) begin fails++; $display("FAIL q_fs_width: got %0d clks expected 1", fs_cnt); end
    checks++; if (fall1 != 2624 || rise1 - fall1 != 384) begin fails++; $display("FAIL q_hs_width: got fall=%0d width=%0d expected 2624 384", fall1, rise1 - fall1); end
    checks++; if (fall2 - fall1 != 3200) begin fails++; $display("FAIL q_line_period: got %0d expected 3200", fall2 - fall1); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_addr();
    test_reset_mid();
    test_hdisp_edge();
    test_frame();
    test_quarter_rate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001 SHALL have parameters (name, default, meaning):
  - H_ACTIVE, 640, visible pixels per line.
  - H_FP, 16, horizontal front porch.
  - H_SYNC, 96, hsync width.
  - H_BP, 48, horizontal back porch.
  - V_ACTIVE, 480, visible lines.
  - V_FP, 10, vertical front porch.
  - V_SYNC, 2, vsync width.
  - V_BP, 33, vertical back porch.
  - SYNC_POL, 0, asserted sync level.
  - IMG_W_LOG2, 8, log2 of image width.
  - IMG_H_LOG2, 8, log2 of image height.
- REQ-002 SHALL have ports (name, direction, width, meaning):
  - clk, in, 1, sole clock.
  - reset, in, 1, asynchronous active-high reset.
  - pix_ce, in, 1, pixel tick enable; all state advances only on clk edges with pix_ce=1.
  - hsync, out, 1, horizontal sync.
  - vsync, out, 1, vertical sync.
  - h_disp, out, 1, horizontal active region.
  - v_disp, out, 1, vertical active region.
  - en, out, 1, pixel lies inside the stored image.
  - addr, out, IMG_W_LOG2+IMG_H_LOG2, image memory read address.
  - x, out, 10, output pixel column.
  - y, out, 10, output pixel row.
  - frame_start, out, 1, start-of-frame pulse.
- REQ-003 One clock domain: clk. reset SHALL be asynchronous and active-high.

Function
- REQ-004 Counters: h_cnt SHALL count 0..H_TOTAL-1 on each pix_ce, where H_TOTAL = sum of the four H params (800 at defaults).
- REQ-005 v_cnt SHALL increment when h_cnt wraps to 0, counting 0..V_TOTAL-1 (525 at defaults). It SHALL wrap to 0 on the same pix_ce that h_cnt wraps at V_TOTAL-1.
- REQ-006 addr SHALL be combinational from the counter registers: {v_cnt[IMG_H_LOG2-1:0], h_cnt[IMG_W_LOG2-1:0]} when h_cnt < 2^IMG_W_LOG2 and v_cnt < 2^IMG_H_LOG2, else 0.
- REQ-007 Output stage: on each pix_ce, hsync, vsync, h_disp, v_disp, en, x and y SHALL be registered from the current counter position. This gives exactly one pix_ce of latency, aligning them with a synchronous ROM that registers addr on pix_ce.
- REQ-008 Region flags:
  - h_disp = (h_cnt < H_ACTIVE).
  - v_disp = (v_cnt < V_ACTIVE).
  - en = in-image condition of REQ-006 AND h_disp AND v_disp.
- REQ-009 Sync timing:
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - vsync is defined analogously using v_cnt and the V params.
- REQ-010 x and y SHALL equal h_cnt and v_cnt of the registered position, including blanking values.
- REQ-011 frame_start SHALL be high for exactly one clk: the cycle after the pix_ce that loads position (0,0) into the output stage.
- REQ-012 When pix_ce=0, all registers and outputs SHALL hold. frame_start SHALL drop after its one clk even if pix_ce stays low.
- REQ-013 h_cnt wrap without v_cnt wrap SHALL affect only v_cnt. A simultaneous h and v wrap SHALL produce (0,0) with no skipped or duplicated line.

Reset
- REQ-014 While reset=1, regardless of clk:
  - h_cnt=0 and v_cnt=0.
  - x=0 and y=0.
  - h_disp=0, v_disp=0, en=0.
  - frame_start=0.
  - hsync=~SYNC_POL and vsync=~SYNC_POL.
  - addr=0.
- REQ-015 Reset mid-frame SHALL abandon the frame. The first pix_ce after release SHALL load pixel (0,0) and pulse frame_start.

Configuration
- REQ-016 Macro VGA_TESTPAT_EN, when defined, SHALL add output pat_rgb (12 bits):
  - Eight vertical colour bars of H_ACTIVE/8 pixels each, in the order white, yellow, cyan, green, magenta, red, blue, black (12'hFFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000).
  - pat_rgb is registered in the output stage with the REQ-007 alignment.
  - pat_rgb = 0 when h_disp or v_disp is 0.
- REQ-017 When VGA_TESTPAT_EN is undefined, pat_rgb and its logic SHALL be absent. All other behaviour is identical.

Verification
- REQ-018 The bench SHALL cover these directed scenarios (default parameters unless stated):
  - pix_ce=1 constantly → hsync low for exactly 96 pixels, x=656..751; line period 800 clk; vsync low on y=490..491; frame_start period 420000 clk.
  - Counter at (5,3) → addr=773; one pix_ce later x=5, y=3, en=1, h_disp=1, v_disp=1.
  - Counter at (256,10) → addr=0, then en=0 with h_disp=1; at (639,479) → en=0, h_disp=1, v_disp=1; at (640,0) → h_disp=0.
  - pix_ce high one clk in four → all intervals scale by 4 exactly; outputs stable between ticks; frame_start width is 1 clk.
  - Reset asserted at x=300, y=200, released → outputs at the reset values of REQ-014; first tick gives x=0, y=0, frame_start=1.
  - VGA_TESTPAT_EN defined → pat_rgb=12'hFFF at x=0, 12'hFF0 at x=80, 12'h000 at x=600, and 0 at x=700.
